// File: rtl/timer_alarm_ctrl.sv
// Multi-channel alarm scheduler on the shared microsecond stamp: per-channel
// one-shot/periodic compare, pending bits, maskable interrupt, UIBI slave.
module timer_alarm_ctrl #(
  parameter int NCH  = 4,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] stamp_i,
  input  logic            bus_req,
  input  logic            bus_wen,
  input  logic [31:0]     bus_addr,
  input  logic [XLEN-1:0] bus_dat_i,
  output logic [XLEN-1:0] bus_dat_o,
  output logic            bus_ready,
  output logic            intr,
  output logic [NCH-1:0]  fire_o
);

  localparam logic [3:0] IDX_CTRL  = 4'd0;
  localparam logic [3:0] IDX_PEND  = 4'd1;
  localparam logic [3:0] IDX_IMASK = 4'd2;
  localparam logic [3:0] IDX_STAMP = 4'd3;

  logic [NCH-1:0]  en, pend, imask;
  logic [XLEN-1:0] cmp [NCH];
  logic [XLEN-1:0] per [NCH];

  logic [NCH-1:0]  en_n, pend_n, imask_n;
  logic [XLEN-1:0] cmp_n [NCH];
  logic [XLEN-1:0] per_n [NCH];

  logic [XLEN-1:0] diff [NCH];
  logic [NCH-1:0]  due, fire;
  logic [XLEN-1:0] rdata;
  logic [3:0]      idx;
  logic            wr, rd;
  logic            unused_addr;

  assign idx         = bus_addr[5:2];
  assign wr          = bus_req & bus_wen;
  assign rd          = bus_req & ~bus_wen;
  assign bus_ready   = 1'b1;
  assign unused_addr = ^{bus_addr[31:6], bus_addr[1:0]};

  // Signed difference keeps the compare correct across stamp wrap for
  // deadlines within half the stamp range. A same-cycle CTRL/CMP write
  // overrides the expiry entirely.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      diff[i] = stamp_i - cmp[i];
      due[i]  = en[i] & ~diff[i][XLEN-1];
      fire[i] = due[i] & ~(wr & ((idx == IDX_CTRL) || (idx == 4'(i + 4))));
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    en_n    = en;
    pend_n  = pend;
    imask_n = imask;
    for (int i = 0; i < NCH; i++) begin
      cmp_n[i] = cmp[i];
      per_n[i] = per[i];
      if (fire[i]) begin
        if (per[i] != '0) cmp_n[i] = cmp[i] + per[i];
        else              en_n[i]  = 1'b0;
      end
    end
    if (wr) begin
      case (idx)
        IDX_CTRL:  en_n    = bus_dat_i[NCH-1:0];
        IDX_PEND:  pend_n  = pend & ~bus_dat_i[NCH-1:0];
        IDX_IMASK: imask_n = bus_dat_i[NCH-1:0];
        default: begin
          for (int i = 0; i < NCH; i++) begin
            if (idx == 4'(i + 4)) cmp_n[i] = bus_dat_i;
            if (idx == 4'(i + 8)) per_n[i] = bus_dat_i;
          end
        end
      endcase
    end
    // A fire beats a same-cycle clearing write.
    pend_n = pend_n | fire;
  end

  always_comb begin
    rdata = '0;
    case (idx)
      IDX_CTRL:  rdata[NCH-1:0] = en;
      IDX_PEND:  rdata[NCH-1:0] = pend;
      IDX_IMASK: rdata[NCH-1:0] = imask;
      IDX_STAMP: rdata          = stamp_i;
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (idx == 4'(i + 4)) rdata = cmp[i];
          if (idx == 4'(i + 8)) rdata = per[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en        <= '0;
      pend      <= '0;
      imask     <= '0;
      bus_dat_o <= '0;
      intr      <= 1'b0;
      fire_o    <= '0;
      // NOTE: the deadline/period arrays are reset too, since software reads them back as 0.
      for (int i = 0; i < NCH; i++) begin
        cmp[i] <= '0;
        per[i] <= '0;
      end
    end else begin
      en        <= en_n;
      pend      <= pend_n;
      imask     <= imask_n;
      fire_o    <= fire;
      intr      <= |(pend_n & imask_n);
      bus_dat_o <= rd ? rdata : '0;
      for (int i = 0; i < NCH; i++) begin
        cmp[i] <= cmp_n[i];
        per[i] <= per_n[i];
      end
    end
  end

endmodule
